// File: rtl/alu_control_pipe.sv
// -----------------------------------------------------------------------------
// alu_control_pipe
//   Registered ALU control stage between ID and EX of the MIPS datapath.
//   It decodes ALUOp/funct into the ALU control code and flags unsupported
//   operations. It also sequences multi-cycle mult/div operations with a busy
//   counter, and throttles the issue stage with a valid/ready handshake.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      issue stage presents funct_in/alu_op
//   in_ready      stage can accept this cycle
//   funct_in      instruction funct field (6 bits)
//   alu_op        main-control ALUOp (2 bits)
//   stall_in      EX cannot take a new control word
//   alu_ctrl      registered ALU control code (CTRL_W bits, upper bits zero)
//   out_valid     alu_ctrl is valid for EX
//   illegal       registered; the decoded op was unsupported
//   muldiv_start  one-cycle pulse; the mult/div unit starts
//   muldiv_done   one-cycle pulse; last busy cycle of the mult/div sequence
//   busy          mult/div sequence in progress
//   state_dbg     1 while the sequencer FSM is in BUSY (observation only)
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
//   in_valid may be raised at any time and the word is held by the issue
//   stage until it transfers. in_ready is low while a mult/div sequence
//   occupies EX, and while the current output word is stalled
//   (out_valid & stall_in). An offer made while in_ready is low is not
//   queued.
// -----------------------------------------------------------------------------
module alu_control_pipe #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        funct_in,
    input  logic [1:0]        alu_op,
    input  logic              stall_in,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              out_valid,
    output logic              illegal,
    output logic              muldiv_start,
    output logic              muldiv_done,
    output logic              busy,
    output logic              state_dbg
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] CTRL_MULT = 4'b1101;
    localparam logic [3:0] CTRL_DIV  = 4'b1110;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic              illegal_q, illegal_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [3:0]        dec_ctrl;
    logic              dec_illegal;
    logic              dec_muldiv;
    logic [CNT_W-1:0]  dec_cnt;
    logic              hold;
    logic              accept;

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        unique case (alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b11: dec_illegal = 1'b1;
            2'b10: begin
                unique case (funct_in)
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b101010: dec_ctrl = 4'b0111;
                    6'b100111: dec_ctrl = 4'b1100;
                    6'b100110: dec_ctrl = 4'b0011;
                    6'b000000: dec_ctrl = 4'b1000;
                    6'b000010: dec_ctrl = 4'b1001;
                    6'b000011: dec_ctrl = 4'b1010;
                    6'b011000: dec_ctrl = CTRL_MULT;
                    6'b011010: dec_ctrl = CTRL_DIV;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // An illegal decode always yields 0000, so it can never look like mult/div.
    assign dec_muldiv = ~dec_illegal & ((dec_ctrl == CTRL_MULT) | (dec_ctrl == CTRL_DIV));
    assign dec_cnt    = (dec_ctrl == CTRL_MULT) ? MUL_CNT : DIV_CNT;

    // ------------------------------------------------------------- handshake
    assign hold     = out_valid_q & stall_in;
    assign in_ready = (state_q == IDLE) & ~hold;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b0;

        // Output word: held while stalled, loaded on accept, otherwise it
        // drops valid but keeps the last code/illegal value.
        if (!hold) begin
            if (accept) begin
                alu_ctrl_d  = CTRL_W'(dec_ctrl);
                illegal_d   = dec_illegal;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // The sequencer is not frozen by stall_in.
        unique case (state_q)
            IDLE: begin
                if (accept && dec_muldiv) begin
                    start_d = 1'b1;
                    if (dec_cnt == '0) begin
                        // Single-cycle op: start and done coincide, no BUSY.
                        done_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = dec_cnt;
                    end
                end
            end
            BUSY: begin
                // The start cycle counts as the first occupied cycle. busy and
                // done are registered, so they are computed one cycle ahead:
                // done is shown in the cycle where the counter reads zero.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            start_q     <= start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_ctrl     = alu_ctrl_q;
    assign out_valid    = out_valid_q;
    assign illegal      = illegal_q;
    assign muldiv_start = start_q;
    assign muldiv_done  = done_q;
    assign busy         = busy_q;
    assign state_dbg    = (state_q == BUSY);

endmodule
